// File: rtl/openram_tc_pkg.sv
// openram_tc_pkg: shared FSM type, SRAM select codes and word widths
// for the OpenRAM test-chip readback path.
package openram_tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_SHIFT
    } rb_state_e;

    localparam logic [2:0] SRAM_CS_0 = 3'd0;
    localparam logic [2:0] SRAM_CS_1 = 3'd1;
    localparam logic [2:0] SRAM_CS_2 = 3'd2;
    localparam logic [2:0] SRAM_CS_3 = 3'd3;
    localparam logic [2:0] SRAM_CS_4 = 3'd4;
    localparam logic [2:0] SRAM_CS_5 = 3'd5;

    localparam int unsigned NARROW_W = 32;
    localparam int unsigned WIDE_W   = 64;

endpackage

// File: rtl/openram_readback_mux.sv
// openram_readback_mux: selects the SRAM dout addressed by the latched
// chip select / port select and flags selects with no macro behind them.
module openram_readback_mux
    import openram_tc_pkg::*;
#(
    parameter int unsigned WIDE_CS = 5
) (
    input  logic [2:0]          cs_i,
    input  logic                ps_i,
    input  logic [NARROW_W-1:0] sram0_rw_i,
    input  logic [NARROW_W-1:0] sram0_r0_i,
    input  logic [NARROW_W-1:0] sram1_rw_i,
    input  logic [NARROW_W-1:0] sram1_ro_i,
    input  logic [NARROW_W-1:0] sram2_rw_i,
    input  logic [NARROW_W-1:0] sram3_rw_i,
    input  logic [NARROW_W-1:0] sram4_rw_i,
    input  logic [WIDE_W-1:0]   sram5_rw_i,
    output logic [WIDE_W-1:0]   data_o,
    output logic                wide_o,
    output logic                bad_o
);

    localparam int unsigned PAD_W = WIDE_W - NARROW_W;

    always_comb begin
        data_o = '0;
        bad_o  = 1'b0;
        unique case (cs_i)
            SRAM_CS_0: data_o = {{PAD_W{1'b0}}, ps_i ? sram0_r0_i : sram0_rw_i};
            SRAM_CS_1: data_o = {{PAD_W{1'b0}}, ps_i ? sram1_ro_i : sram1_rw_i};
            SRAM_CS_2: data_o = {{PAD_W{1'b0}}, sram2_rw_i};
            SRAM_CS_3: data_o = {{PAD_W{1'b0}}, sram3_rw_i};
            SRAM_CS_4: data_o = {{PAD_W{1'b0}}, sram4_rw_i};
            SRAM_CS_5: data_o = sram5_rw_i;
            default:   bad_o  = 1'b1;
        endcase
    end

    assign wide_o = (cs_i == 3'(WIDE_CS));

endmodule

// File: rtl/openram_readback.sv
// openram_readback: captures SRAM read data, holds it for LA readback and
// shifts it MSB-first on GPIO. Optional parity bit: OPENRAM_READBACK_PARITY_EN.
module openram_readback
    import openram_tc_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WIDE_CS      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_req,
    input  logic [2:0]          chip_select,
    input  logic                port_sel,
    input  logic [NARROW_W-1:0] sram0_rw_in,
    input  logic [NARROW_W-1:0] sram0_r0_in,
    input  logic [NARROW_W-1:0] sram1_rw_in,
    input  logic [NARROW_W-1:0] sram1_ro_in,
    input  logic [NARROW_W-1:0] sram2_rw_in,
    input  logic [NARROW_W-1:0] sram3_rw_in,
    input  logic [NARROW_W-1:0] sram4_rw_in,
    input  logic [WIDE_W-1:0]   sram5_rw_in,
    input  logic                clr_status,
    output logic [WIDE_W-1:0]   sram_data,
    output logic                data_valid,
    output logic                ser_out,
    output logic                ser_frame,
    output logic                busy,
    output logic                overrun,
    output logic                bad_cs
`ifdef OPENRAM_READBACK_PARITY_EN
    ,
    output logic                parity_out
`endif
);

    localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

    rb_state_e         state_q, state_d;
    logic [2:0]        cs_q, cs_d;
    logic              ps_q, ps_d;
    logic [2:0]        wait_q, wait_d;
    logic [5:0]        bit_q, bit_d;
    logic [WIDE_W-1:0] sh_q, sh_d;
    logic [WIDE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              bad_q, bad_d;
`ifdef OPENRAM_READBACK_PARITY_EN
    logic              par_q, par_d;
    logic              pph_q, pph_d;
`endif

    logic [WIDE_W-1:0] mux_data;
    logic              mux_wide;
    logic              mux_bad;

    openram_readback_mux #(
        .WIDE_CS(WIDE_CS)
    ) u_mux (
        .cs_i      (cs_q),
        .ps_i      (ps_q),
        .sram0_rw_i(sram0_rw_in),
        .sram0_r0_i(sram0_r0_in),
        .sram1_rw_i(sram1_rw_in),
        .sram1_ro_i(sram1_ro_in),
        .sram2_rw_i(sram2_rw_in),
        .sram3_rw_i(sram3_rw_in),
        .sram4_rw_i(sram4_rw_in),
        .sram5_rw_i(sram5_rw_in),
        .data_o    (mux_data),
        .wide_o    (mux_wide),
        .bad_o     (mux_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
            ps_q    <= 1'b0;
            wait_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            bad_q   <= 1'b0;
`ifdef OPENRAM_READBACK_PARITY_EN
            par_q   <= 1'b0;
            pph_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            ps_q    <= ps_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            bad_q   <= bad_d;
`ifdef OPENRAM_READBACK_PARITY_EN
            par_q   <= par_d;
            pph_q   <= pph_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        ps_d    = ps_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        bad_d   = bad_q;
`ifdef OPENRAM_READBACK_PARITY_EN
        par_d   = par_q;
        pph_d   = pph_q;
`endif
        // Clear first so a same-cycle set condition overrides it.
        if (clr_status) begin
            ovr_d = 1'b0;
            bad_d = 1'b0;
        end
        if (read_req && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (read_req) begin
                    cs_d    = chip_select;
                    ps_d    = port_sel;
                    wait_d  = WAIT_INIT;
                    valid_d = 1'b0;
                    state_d = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q <= 3'd1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                data_d  = mux_data;
                valid_d = 1'b1;
                // Narrow words are left-aligned so the MSB is always sh_q[63].
                sh_d    = mux_wide ? mux_data
                                   : {mux_data[NARROW_W-1:0], {NARROW_W{1'b0}}};
                bit_d   = mux_wide ? 6'(WIDE_W - 1) : 6'(NARROW_W - 1);
                if (mux_bad) begin
                    bad_d = 1'b1;
                end
`ifdef OPENRAM_READBACK_PARITY_EN
                par_d   = ^mux_data;
                pph_d   = 1'b0;
`endif
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_d = {sh_q[WIDE_W-2:0], 1'b0};
                if (bit_q != 6'd0) begin
                    bit_d = bit_q - 6'd1;
                end
`ifdef OPENRAM_READBACK_PARITY_EN
                if (pph_q) begin
                    pph_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (bit_q == 6'd0) begin
                    pph_d = 1'b1;
                end
`else
                if (bit_q == 6'd0) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sram_data  = data_q;
    assign data_valid = valid_q;
    assign ser_frame  = (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = ovr_q;
    assign bad_cs     = bad_q;
`ifdef OPENRAM_READBACK_PARITY_EN
    assign ser_out    = ser_frame & (pph_q ? par_q : sh_q[WIDE_W-1]);
    assign parity_out = par_q;
`else
    assign ser_out    = ser_frame & sh_q[WIDE_W-1];
`endif

endmodule

// File: tb/tb_openram_readback.sv
// tb_openram_readback: randomized scoreboard bench for openram_readback;
// expected frames are queued at issue and checked by a serial-pin monitor.
module tb_openram_readback;

    localparam int RL = 2;
`ifdef OPENRAM_READBACK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [63:0] data;
        int          width;
        int          first;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_req = 1'b0;
    logic [2:0]  chip_select = '0;
    logic        port_sel = 1'b0;
    logic        clr_status = 1'b0;
    logic [31:0] rw_v [5];
    logic [31:0] ro_v [2];
    logic [63:0] w_v;
    logic [31:0] st_rw [5];
    logic [31:0] st_ro [2];
    logic [63:0] st_w;
    logic [63:0] sram_data;
    logic        data_valid, ser_out, ser_frame, busy, overrun, bad_cs;
`ifdef OPENRAM_READBACK_PARITY_EN
    logic        parity_out;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_busy = 0;
    exp_t q[$];
    exp_t cur;
    int   nbits = 0;
    bit   in_frame = 0;
    bit   bad_exp = 0;

    openram_readback #(
        .READ_LATENCY(RL),
        .WIDE_CS(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_req   (read_req),
        .chip_select(chip_select),
        .port_sel   (port_sel),
        .sram0_rw_in(rw_v[0]),
        .sram0_r0_in(ro_v[0]),
        .sram1_rw_in(rw_v[1]),
        .sram1_ro_in(ro_v[1]),
        .sram2_rw_in(rw_v[2]),
        .sram3_rw_in(rw_v[3]),
        .sram4_rw_in(rw_v[4]),
        .sram5_rw_in(w_v),
        .clr_status (clr_status),
        .sram_data  (sram_data),
        .data_valid (data_valid),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .busy       (busy),
        .overrun    (overrun),
        .bad_cs     (bad_cs)
`ifdef OPENRAM_READBACK_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: which dout a (cs, port) pair reads, zero-extended.
    function automatic logic [63:0] ref_data(input int cs, input bit ps);
        if (cs < 2) return ps ? {32'b0, ro_v[cs]} : {32'b0, rw_v[cs]};
        if (cs < 5) return {32'b0, rw_v[cs]};
        if (cs == 5) return w_v;
        return 64'b0;
    endfunction

    task automatic scramble();
        foreach (rw_v[i]) rw_v[i] = $urandom;
        foreach (ro_v[i]) ro_v[i] = $urandom;
        w_v = {$urandom, $urandom};
    endtask

    task automatic stage_random();
        foreach (st_rw[i]) st_rw[i] = $urandom;
        foreach (st_ro[i]) st_ro[i] = $urandom;
        st_w = {$urandom, $urandom};
    endtask

    // Staged values are on the buses only during the capture cycle.
    task automatic do_read(input int cs, input bit ps, output int k);
        exp_t e;
        @(posedge clk); #1;
        scramble();
        chip_select = 3'(cs);
        port_sel = ps;
        read_req = 1'b1;
        k = cyc;
        e.first = cyc + RL + 1;
        @(posedge clk); #1;
        read_req = 1'b0;
        chip_select = 3'($urandom);
        port_sel = 1'($urandom);
        @(negedge clk);
        chk("dv_clear", data_valid, 1'b0);
        repeat (RL - 1) @(posedge clk);
        #1;
        rw_v = st_rw;
        ro_v = st_ro;
        w_v = st_w;
        e.data = ref_data(cs, ps);
        e.width = (cs == 5) ? 64 : 32;
        q.push_back(e);
        @(posedge clk); #1;
        scramble();
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic pulse(input bit req, input bit clr);
        #1;
        read_req = req;
        clr_status = clr;
        @(posedge clk); #1;
        read_req = 1'b0;
        clr_status = 1'b0;
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) last_busy = cyc;
        if (reset) begin
            in_frame = 0;
        end else if (ser_frame) begin
            if (!in_frame) begin
                in_frame = 1;
                nbits = 0;
                chk("frame_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) cur = q.pop_front();
                else cur = '{data: 64'b0, width: 32, first: cyc};
                chk("first_bit_cyc", 64'(cyc), 64'(cur.first));
                chk("sram_data", sram_data, cur.data);
                chk("data_valid", data_valid, 1'b1);
            end
            if (nbits < cur.width) chk("ser_bit", ser_out, cur.data[cur.width-1-nbits]);
            else chk("parity_bit", ser_out, ^cur.data);
            nbits++;
        end else begin
            chk("idle_ser_out", ser_out, 1'b0);
            if (in_frame) begin
                in_frame = 0;
                chk("frame_len", 64'(nbits), 64'(cur.width + PAR));
`ifdef OPENRAM_READBACK_PARITY_EN
                chk("parity_out", parity_out, ^cur.data);
`endif
            end
        end
    end

    initial begin
        int k;
        int cs;
        scramble();
        stage_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", sram_data, 64'b0);
        chk("rst_flags", {data_valid, ser_out, ser_frame, busy, overrun, bad_cs}, 6'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        st_rw[2] = 32'hDEADBEEF;
        do_read(2, 0, k);
        wait_idle();
        chk("dv_hold", data_valid, 1'b1);

        stage_random();
        st_w = 64'h0123456789ABCDEF;
        do_read(5, 1, k);
        wait_idle();
        chk("busy_span", 64'(last_busy - k + 1), 64'(RL + 1 + 64 + PAR));

        stage_random();
        st_ro[1] = 32'hA5A5A5A5;
        st_rw[1] = 32'hFFFFFFFF;
        do_read(1, 1, k);
        wait_idle();

        stage_random();
        st_rw[2] = 32'h00000001;
        do_read(2, 0, k);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            stage_random();
            cs = $urandom_range(0, 7);
            if (cs > 5) bad_exp = 1;
            do_read(cs, 1'($urandom), k);
            wait_idle();
            chk("bad_cs_sticky", bad_cs, bad_exp);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(posedge clk);
        pulse(0, 1);
        @(negedge clk);
        chk("bad_cs_clr", bad_cs, 1'b0);
        chk("overrun_pre", overrun, 1'b0);

        stage_random();
        do_read(3, 0, k);
        repeat (5) @(posedge clk);
        pulse(1, 0);
        @(negedge clk);
        chk("overrun_set", overrun, 1'b1);
        @(posedge clk);
        pulse(1, 1);
        @(negedge clk);
        chk("overrun_set_wins", overrun, 1'b1);
        wait_idle();
        chk("overrun_sticky", overrun, 1'b1);
        @(posedge clk);
        pulse(0, 1);
        @(negedge clk);
        chk("overrun_clr", overrun, 1'b0);

        stage_random();
        do_read(4, 1, k);
        repeat (31 + PAR) @(posedge clk);
        pulse(1, 0);
        @(negedge clk);
        chk("overrun_last_cycle", overrun, 1'b1);
        chk("busy_after_last", busy, 1'b0);
        wait_idle();
        @(posedge clk);
        pulse(0, 1);

        stage_random();
        do_read(7, 0, k);
        @(negedge clk);
        chk("bad_cs_set", bad_cs, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_data", sram_data, 64'b0);
        chk("midrst_flags", {data_valid, ser_out, ser_frame, busy, overrun, bad_cs}, 6'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("no_partial_frame", ser_frame, 1'b0);

        stage_random();
        do_read($urandom_range(0, 5), 1'($urandom), k);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/openram_readback.md
Name: openram_readback

Overview:
- Return path of the OpenRAM test chip: captures read data from the selected SRAM macro after a host-issued read.
- Holds the captured word in a parallel register for logic-analyzer readback.
- Serialises the word MSB-first on a GPIO output pin with a frame strobe, so a host can read SRAM contents over GPIO as well as LA.
- Sits beside the LA/GPIO request decoder and is clocked by the same muxed wb/gpio clock.

Parameters:
- READ_LATENCY, 2, cycles from read_req to a valid SRAM dout sample (legal range 1..7).
- WIDE_CS, 5, chip_select value whose macro is 64 bits wide; all other macros are 32 bits.

Ports:
- clk  in  1  muxed wb/gpio clock; the only clock.
- reset  in  1  synchronous, active-high.
- read_req  in  1  one-cycle pulse; a read was launched to the selected SRAM this cycle.
- chip_select  in  3  SRAM select registered with the request (0..5 valid).
- port_sel  in  1  0 = rw-port dout, 1 = read-only-port dout (macros 0/1 only).
- sram0_rw_in  in  32  macro 0 rw dout.
- sram0_r0_in  in  32  macro 0 r dout.
- sram1_rw_in  in  32  macro 1 rw dout.
- sram1_ro_in  in  32  macro 1 r dout.
- sram2_rw_in, sram3_rw_in, sram4_rw_in  in  32 each  macros 2-4 dout.
- sram5_rw_in  in  64  macro 5 dout.
- clr_status  in  1  clears the sticky flags.
- sram_data  out  64  last captured word, zero-extended for 32-bit macros.
- data_valid  out  1  high from capture until the next read_req is accepted.
- ser_out  out  1  serial data bit.
- ser_frame  out  1  high during every serial bit time.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: a read_req arrived while busy.
- bad_cs  out  1  sticky: a capture happened with chip_select 6 or 7.

Behaviour:
- Reset (synchronous): state = IDLE; sram_data = 0; data_valid, ser_out, ser_frame, busy, overrun, bad_cs = 0; counters = 0.
- Reset mid-operation: a shift or wait in progress aborts immediately; no partial frame continues after reset.
- FSM states: IDLE, WAIT, CAPTURE, SHIFT.
- IDLE:
  - On read_req, latch chip_select and port_sel, load wait_cnt = READ_LATENCY-1, clear data_valid.
  - Next state is WAIT, or CAPTURE directly if READ_LATENCY = 1.
- WAIT: decrement wait_cnt; go to CAPTURE when it reaches 0.
- CAPTURE (one cycle), mux the latched select:
  - cs 0/1: rw_in when port_sel = 0, r port when port_sel = 1.
  - cs 2-4: rw_in; port_sel is ignored.
  - cs WIDE_CS: full 64 bits.
  - cs 6/7: data 0 and set bad_cs.
  - Write sram_data; data_valid = 1; shift register = data; bit_cnt = 31, or 63 for WIDE_CS. Next state SHIFT.
- SHIFT:
  - Each cycle: ser_frame = 1, ser_out = shift register MSB of the active width; shift left; decrement bit_cnt.
  - After the bit with bit_cnt = 0, return to IDLE; ser_frame drops on the following cycle.
- Total read_req-to-first-serial-bit latency = READ_LATENCY + 1 cycles.
- Frame length is 32 or 64 cycles (plus 1 with the optional feature). ser_out = 0 whenever ser_frame = 0.
- read_req while busy: request dropped, overrun set; the in-flight operation is undisturbed.
- read_req in the same cycle the FSM returns to IDLE: still busy, so the request is dropped and overrun is set. No back-to-back pipelining.
- clr_status and a new set condition in the same cycle: set wins.
- chip_select/port_sel changes after the request do not affect the capture (latched values are used).

Optional Feature:
- Macro OPENRAM_READBACK_PARITY_EN.
- Defined:
  - One extra SHIFT cycle after the last data bit carries even parity (XOR of all data bits of the active width), with ser_frame still high.
  - A parity_out (1) port mirrors that parity bit and holds it until the next capture.
- Undefined: no parity bit and no parity_out port; frame length is exactly 32/64.

Decomposition:
- Package openram_tc_pkg holds:
  - state enum (IDLE/WAIT/CAPTURE/SHIFT);
  - SRAM_CS_* select constants 0..5;
  - NARROW_W = 32, WIDE_W = 64.
- One sub-module, openram_readback_mux: combinational dout selection by (chip_select, port_sel), including the bad-select flag.
- FSM and shifter stay in the top module.

Test Plan:
- cs = 2, sram2_rw_in = 0xDEADBEEF, read_req, READ_LATENCY = 2:
  - sram_data = 0x00000000DEADBEEF and data_valid after 3 cycles;
  - ser_frame high 32 cycles, bits 1101_1110… MSB first.
- cs = 5, sram5_rw_in = 0x0123456789ABCDEF: 64-bit frame; first bit 0, last bit 1; busy exactly 2+1+64 cycles.
- cs = 1, port_sel = 1, sram1_ro_in = 0xA5A5A5A5, sram1_rw_in = 0xFFFFFFFF: captured value is 0xA5A5A5A5.
- Second read_req issued mid-SHIFT: overrun = 1, the first frame completes intact; clr_status then clears overrun to 0.
- cs = 7 read: sram_data = 0, bad_cs = 1, a 32-bit all-zero frame; reset asserted at SHIFT bit 10: next cycle all outputs are 0 and state is IDLE.
- With OPENRAM_READBACK_PARITY_EN, data 0x00000001: 33-cycle frame, final bit = 1, parity_out = 1.
